// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
//
// Control stage for an 8-entry synchronous FIFO. It turns raw push/pop
// requests into gated write/read enables and addresses. It also keeps the
// head/tail pointers and the occupancy count, and it reports full/empty plus
// per-operation ack/error status one cycle after each request.
//
// Ports:
//   clk         rising-edge system clock
//   reset_n     asynchronous active-low reset
//   wr_en       push request for this cycle
//   rd_en       pop request for this cycle
//   we          gated write enable (wr_en & ~full) to the write decode stage
//   wAddr       write address (tail pointer)
//   re          gated read enable (rd_en & ~empty) to the read stage
//   rAddr       read address (head pointer)
//   full        occupancy == depth
//   empty       occupancy == 0
//   data_count  current occupancy, 0..depth
//   wr_ack      previous cycle's push was accepted
//   wr_err      previous cycle's push was rejected (FIFO full)
//   rd_ack      previous cycle's pop was accepted
//   rd_err      previous cycle's pop was rejected (FIFO empty)
// -----------------------------------------------------------------------------
module fifo_ctrl #(
   parameter int ADDR_W = 3,
   parameter int CNT_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic              re,
   output logic [ADDR_W-1:0] rAddr,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  data_count,
   output logic              wr_ack,
   output logic              wr_err,
   output logic              rd_ack,
   output logic              rd_err
);

   localparam int DEPTH = 2 ** ADDR_W;

   // The state records the most recent operation. Its only job is to drive
   // the status outputs.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      READ   = 3'd2,
      WR_RD  = 3'd3,
      WR_ERR = 3'd4,
      RD_ERR = 3'd5
   } state_t;

   logic [ADDR_W-1:0] tail_q, tail_d;
   logic [ADDR_W-1:0] head_q, head_d;
   logic [CNT_W-1:0]  count_q, count_d;
   state_t            state_q, state_d;
   // In the error states, this bit records whether the opposite request
   // was accepted in the same cycle.
   logic              other_ok_q, other_ok_d;

   // full/empty come only from the count. A head==tail compare cannot tell
   // an empty FIFO from a full one.
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

   assign we    = wr_en & ~full;
   assign re    = rd_en & ~empty;
   assign wAddr = tail_q;
   assign rAddr = head_q;
   assign data_count = count_q;

   always_comb begin
      // NOTE: every signal gets a default before any branch. Without one, a
      // path that skips the assignment would infer a latch.
      tail_d     = tail_q;
      head_d     = head_q;
      count_d    = count_q;
      state_d    = IDLE;
      other_ok_d = 1'b0;

      // The pointers are exactly ADDR_W bits wide, so the increment wraps
      // modulo depth by itself.
      if (we) tail_d = tail_q + ADDR_W'(1);
      if (re) head_d = head_q + ADDR_W'(1);

      unique case ({we, re})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A push rejection takes priority. Both sides cannot be rejected in
      // the same cycle, because full and empty are mutually exclusive.
      if (wr_en && full) begin
         state_d    = WR_ERR;
         other_ok_d = re;
      end else if (rd_en && empty) begin
         state_d    = RD_ERR;
         other_ok_d = we;
      end else if (we && re) begin
         state_d = WR_RD;
      end else if (we) begin
         state_d = WRITE;
      end else if (re) begin
         state_d = READ;
      end else begin
         state_d = IDLE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples values from before the edge. This avoids simulation races
   // between blocks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tail_q     <= '0;
         head_q     <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         other_ok_q <= 1'b0;
      end else begin
         tail_q     <= tail_d;
         head_q     <= head_d;
         count_q    <= count_d;
         state_q    <= state_d;
         other_ok_q <= other_ok_d;
      end
   end

   // Status is decoded from registered state only, so it is glitch-free and
   // appears one cycle after the request.
   assign wr_ack = (state_q == WRITE) || (state_q == WR_RD) ||
                   ((state_q == RD_ERR) && other_ok_q);
   assign rd_ack = (state_q == READ) || (state_q == WR_RD) ||
                   ((state_q == WR_ERR) && other_ok_q);
   assign wr_err = (state_q == WR_ERR);
   assign rd_err = (state_q == RD_ERR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
//
// Directed and randomized bench for fifo_ctrl. The reference model counts the
// pushes and pops accepted since reset. Expected pointers are those totals
// modulo 8, and the expected occupancy is their difference. Status
// expectations come from what happened to the previous cycle's requests.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;

   logic       clk;
   logic       reset_n;
   logic       wr_en;
   logic       rd_en;
   logic       we;
   logic [2:0] wAddr;
   logic       re;
   logic [2:0] rAddr;
   logic       full;
   logic       empty;
   logic [3:0] data_count;
   logic       wr_ack;
   logic       wr_err;
   logic       rd_ack;
   logic       rd_err;

   fifo_ctrl #(.ADDR_W(3), .CNT_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .we         (we),
      .wAddr      (wAddr),
      .re         (re),
      .rAddr      (rAddr),
      .full       (full),
      .empty      (empty),
      .data_count (data_count),
      .wr_ack     (wr_ack),
      .wr_err     (wr_err),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: totals of accepted operations since reset, plus the
   // fate of the previous cycle's requests.
   int   n_push = 0;
   int   n_pop  = 0;
   logic p_wr_ack = 1'b0;
   logic p_wr_err = 1'b0;
   logic p_rd_ack = 1'b0;
   logic p_rd_err = 1'b0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      n_push   = 0;
      n_pop    = 0;
      p_wr_ack = 1'b0;
      p_wr_err = 1'b0;
      p_rd_ack = 1'b0;
      p_rd_err = 1'b0;
   endtask

   // Compare every visible output against the model. The request inputs must
   // already be applied.
   task automatic check_all(input string phase);
      int   occ;
      logic acc_w;
      logic acc_r;
      occ   = n_push - n_pop;
      acc_w = wr_en && (occ < 8);
      acc_r = rd_en && (occ > 0);
      check({phase, ".we"},     8'(we),         8'(acc_w));
      check({phase, ".re"},     8'(re),         8'(acc_r));
      check({phase, ".wAddr"},  8'(wAddr),      8'(n_push % 8));
      check({phase, ".rAddr"},  8'(rAddr),      8'(n_pop % 8));
      check({phase, ".count"},  8'(data_count), 8'(occ));
      check({phase, ".full"},   8'(full),       8'(occ == 8));
      check({phase, ".empty"},  8'(empty),      8'(occ == 0));
      check({phase, ".wr_ack"}, 8'(wr_ack),     8'(p_wr_ack));
      check({phase, ".wr_err"}, 8'(wr_err),     8'(p_wr_err));
      check({phase, ".rd_ack"}, 8'(rd_ack),     8'(p_rd_ack));
      check({phase, ".rd_err"}, 8'(rd_err),     8'(p_rd_err));
   endtask

   // One cycle, entered and left on a falling edge. Apply the requests, check
   // the outputs mid-cycle, advance the model at the rising edge, and return
   // on the next falling edge.
   task automatic step(input string phase, input logic w, input logic r);
      int   occ;
      logic acc_w;
      logic acc_r;
      wr_en = w;
      rd_en = r;
      #1;
      check_all(phase);
      occ   = n_push - n_pop;
      acc_w = w && (occ < 8);
      acc_r = r && (occ > 0);
      @(posedge clk);
      if (acc_w) n_push++;
      if (acc_r) n_pop++;
      p_wr_ack = w && acc_w;
      p_wr_err = w && !acc_w;
      p_rd_ack = r && acc_r;
      p_rd_err = r && !acc_r;
      @(negedge clk);
   endtask

   initial begin
      int pw;
      int pr;
      reset_n = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      model_reset();
      #3;
      check_all("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // 1: fill with 8 pushes. 2: ninth push while full.
      for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0);
      step("push_full", 1'b1, 1'b0);
      step("after_push_full", 1'b0, 1'b0);

      // 3: drain with 8 pops, then one pop while empty.
      for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1);
      step("pop_empty", 1'b0, 1'b1);
      step("after_pop_empty", 1'b0, 1'b0);

      // 4: fill to 3, then 10 cycles of simultaneous push+pop. Both pointers
      //    wrap around.
      for (int i = 0; i < 3; i++) step("pre_wrap", 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) step("wrap", 1'b1, 1'b1);
      step("after_wrap", 1'b0, 1'b0);

      // 5: simultaneous push+pop at empty, then at full.
      for (int i = 0; i < 3; i++) step("to_empty", 1'b0, 1'b1);
      step("both_empty", 1'b1, 1'b1);
      step("after_both_empty", 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step("to_full", 1'b1, 1'b0);
      step("both_full", 1'b1, 1'b1);
      step("after_both_full", 1'b0, 1'b0);

      // 6: asynchronous reset mid-fill at count 5, between clock edges.
      for (int i = 0; i < 7; i++) step("to_empty2", 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step("mid_fill", 1'b1, 1'b0);
      wr_en = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      wr_en = 1'b0;
      #1;
      check_all("async_reset");
      @(negedge clk);
      reset_n = 1'b1;
      step("post_reset_push", 1'b1, 1'b0);
      step("post_reset_idle", 1'b0, 1'b0);

      // Randomized traffic. Each block of cycles uses its own push/pop bias,
      // so the FIFO repeatedly sweeps between empty and full.
      for (int blk = 0; blk < 12; blk++) begin
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int i = 0; i < 40; i++)
            step("random", ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr));
      end
      step("final", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control stage of the 8-entry synchronous FIFO.
- Sits directly upstream of the write-enable decode stage and the read mux.
- Turns the raw push/pop requests into a gated write enable plus write address, and a gated read enable plus read address.
- Keeps head/tail pointers and an occupancy count, and reports full/empty and per-operation ack/error status through a small state machine.

Parameters:
ADDR_W, 3, pointer width; FIFO depth is 2**ADDR_W (8 entries, matches the 3-to-8 write decode)
CNT_W, 4, occupancy count width (ADDR_W+1)

Ports:
clk  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  push request for this cycle
rd_en  input  1  pop request for this cycle
we  output  1  gated write enable to the write decode stage
wAddr  output  ADDR_W  write address (tail pointer) to the write decode stage
re  output  1  gated read enable to the read stage
rAddr  output  ADDR_W  read address (head pointer) to the read mux
full  output  1  count == 8
empty  output  1  count == 0
data_count  output  CNT_W  current occupancy, 0..8
wr_ack  output  1  previous cycle's push was accepted
wr_err  output  1  previous cycle's push was rejected (FIFO was full)
rd_ack  output  1  previous cycle's pop was accepted
rd_err  output  1  previous cycle's pop was rejected (FIFO was empty)

Behaviour:
- Clock and reset:
  - One clock domain.
  - reset_n low asynchronously forces tail=0, head=0, data_count=0 and state=IDLE.
  - During reset, outputs are: wAddr=0, rAddr=0, full=0, empty=1, and all ack/err = 0.
  - we and re follow their combinational equations below, so they read 0 while wr_en and rd_en are 0.
  - Reset asserted mid-operation discards all pointers and count immediately; there is no completion of an in-flight push.
- Accept rules (combinational, same cycle):
  - we = wr_en & ~full
  - re = rd_en & ~empty
  - wAddr = tail, rAddr = head, both driven straight from the registers.
  - The decode stage captures the data at the same rising edge that advances tail.
- Pointer and count update on the rising edge:
  - If we, tail <= tail+1, wrapping modulo 8 (7 -> 0).
  - If re, head <= head+1, wrapping modulo 8.
  - data_count: +1 if we only, -1 if re only, unchanged if both or neither.
  - full and empty are decoded from the registered data_count. They are never derived from head == tail alone.
- Simultaneous push and pop:
  - Each is judged independently against the current full/empty.
  - When empty, the push is accepted and the pop is rejected; count becomes 1.
  - When full, the pop is accepted and the push is rejected; count becomes 7.
  - Otherwise both are accepted and count is unchanged.
- State machine (registered, next state from this cycle's requests; records the last operation):
  - IDLE: no request.
  - WRITE: push accepted, no pop.
  - READ: pop accepted, no push.
  - WR_RD: both accepted.
  - WR_ERR: push rejected; any pop accepted.
  - RD_ERR: pop rejected; any push accepted.
  - From any state, the next state is chosen purely from (wr_en, rd_en, full, empty) in the current cycle.
  - Priority when a request is rejected: WR_ERR wins over RD_ERR. Both cannot be rejected together.
- Status outputs are decoded from the state, so they are valid one cycle after the request:
  - wr_ack = WRITE | WR_RD | (RD_ERR & push accepted)
  - rd_ack = READ | WR_RD | (WR_ERR & pop accepted)
  - wr_err = WR_ERR, rd_err = RD_ERR
  - Store the accepted-other-side bit alongside the state.
- Invariants:
  - data_count never leaves 0..8.
  - full and empty are never 1 together.
  - tail − head (mod 8) equals data_count mod 8.

Test Plan:
1. Reset, then 8 pushes with no pops:
   - wAddr steps 0..7 with we=1 each cycle.
   - data_count reaches 8 and full=1.
   - wr_ack=1 in each following cycle.
2. Ninth push while full:
   - we=0, tail stays 0, data_count stays 8.
   - wr_err=1 next cycle and wr_ack=0.
3. 8 pops from full:
   - rAddr steps 0..7 with re=1.
   - empty=1 after the last pop.
   - A further pop gives re=0 and rd_err=1 next cycle.
4. Wrap-around with simultaneous operations:
   - Fill to 3, then push+pop together for 10 cycles.
   - Both pointers wrap 7 -> 0 and data_count stays 3.
   - State is WR_RD, with wr_ack=rd_ack=1.
5. Simultaneous operations at the boundaries:
   - Push+pop when empty: count 0->1, wr_ack=1, rd_err=1.
   - Push+pop when full: count 8->7, rd_ack=1, wr_err=1.
6. Reset in the middle of a fill:
   - Drop reset_n asynchronously mid-fill at count=5 (between clock edges).
   - Outputs clear immediately: empty=1, pointers=0, status=0.
   - A push after reset_n is released lands at wAddr=0.
